// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  // A zero divider would stall the bit timer, so it is promoted to 1.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push is accepted when full
// if a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] CntFull = Depth[AW:0];

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CntFull);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port: TX FIFO,
// STATUS and BAUDDIV registers, and a frame serialiser.
//
// state | meaning
// IDLE  | line high; pops the FIFO head when a byte is waiting
// START | line low for div_q cycles
// DATA  | shift[0] on the line, div_q cycles per bit, 8 bits LSB first
// STOP  | line high for div_q cycles
module uart_tx_responder
  import uart_pkg::*;
#(
  parameter int unsigned           RegBits   = 32,
  parameter logic [RegBits-1:0]    BaseAddr  = 32'h0000_1000,
  parameter int unsigned           FifoDepth = 8,
  parameter int unsigned           ClkDiv    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [RegBits-1:0] a_i,
  input  logic [RegBits-1:0] wd_i,
  input  logic               we_i,
  output logic [RegBits-1:0] rd_o,
  output logic               tx_o,
  output logic               irq_o
);

  localparam int unsigned CntW     = $clog2(FifoDepth) + 1;
  localparam logic [15:0] DivReset = ClkDiv[15:0];

  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_timer;
  logic [15:0] r_div_q;
  logic [15:0] r_bauddiv;
  logic        r_ovf;

  state_t      w_state_nxt;
  logic [7:0]  w_shift_nxt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [15:0] w_timer_nxt;
  logic [15:0] w_div_q_nxt;

  logic            w_sel;
  logic [1:0]      w_off;
  logic            w_wr_tx;
  logic            w_wr_status;
  logic            w_wr_baud;
  logic            w_fifo_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [7:0]      w_fifo_head;
  logic [CntW-1:0] w_fifo_count;
  logic            w_unused;

  assign w_sel       = (a_i[RegBits-1:4] == BaseAddr[RegBits-1:4]);
  assign w_off       = a_i[3:2];
  assign w_wr_tx     = we_i && w_sel && (w_off == OFF_TXDATA);
  assign w_wr_status = we_i && w_sel && (w_off == OFF_STATUS);
  assign w_wr_baud   = we_i && w_sel && (w_off == OFF_BAUDDIV);
  assign w_unused    = ^{a_i[1:0], wd_i[RegBits-1:16], w_fifo_count};

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_wr_tx),
    .wdata_i (wd_i[7:0]),
    .pop_i   (w_fifo_pop),
    .rdata_o (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // A push that finds the FIFO full is only dropped if the serialiser
  // is not freeing a slot on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bauddiv <= DivReset;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_baud) r_bauddiv <= div_sanitize(wd_i[15:0]);
      if (w_wr_status && wd_i[ST_OVF]) begin
        r_ovf <= 1'b0;
      end else if (w_wr_tx && w_fifo_full && !w_fifo_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_timer   <= '0;
      r_div_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_div_q   <= w_div_q_nxt;
    end
  end

  // Each line state holds for div_q cycles: the timer is loaded with
  // div_q-1 and the state advances on terminal count zero.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_timer_nxt   = r_timer;
    w_div_q_nxt   = r_div_q;
    w_fifo_pop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop    = 1'b1;
          w_shift_nxt   = w_fifo_head;
          w_div_q_nxt   = r_bauddiv;
          w_timer_nxt   = r_bauddiv - 16'd1;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (r_timer == 16'd0) begin
          w_timer_nxt = r_div_q - 16'd1;
          w_state_nxt = DATA;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      DATA: begin
        if (r_timer == 16'd0) begin
          w_timer_nxt = r_div_q - 16'd1;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      STOP: begin
        if (r_timer == 16'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = r_shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign irq_o = w_fifo_empty && (r_state == IDLE);

  always_comb begin
    rd_o = '0;
    if (w_sel) begin
      case (w_off)
        OFF_STATUS: begin
          rd_o[ST_EMPTY] = w_fifo_empty;
          rd_o[ST_FULL]  = w_fifo_full;
          rd_o[ST_BUSY]  = (r_state != IDLE);
          rd_o[ST_OVF]   = r_ovf;
        end
        OFF_BAUDDIV: rd_o[15:0] = r_bauddiv;
        default:     rd_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench: a line monitor decodes every frame on tx_o against a
// scoreboard of expected {byte, divider} entries pushed when stores are issued.
`timescale 1ns/1ps
module tb_uart_tx_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_BD  = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [31:0] a_i   = '0;
  logic [31:0] wd_i  = '0;
  logic [31:0] rd_o;
  logic        tx_o;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  uart_tx_responder #(
    .RegBits   (32),
    .BaseAddr  (BASE),
    .FifoDepth (8),
    .ClkDiv    (16)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .a_i   (a_i),
    .wd_i  (wd_i),
    .we_i  (we_i),
    .rd_o  (rd_o),
    .tx_o  (tx_o),
    .irq_o (irq_o)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  int     n_pass = 0;
  int     n_total = 0;
  int     cyc = 0;
  int     mon_frames = 0;
  int     mon_starts = 0;
  bit     mon_busy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Line monitor: samples on the falling edge, one sample per bit-cycle.
  initial begin : monitor
    logic   prev;
    frame_t f;
    int     bad;
    int     slot;
    bit     aborted;
    logic   expb;
    prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!rst_i && prev === 1'b1 && tx_o === 1'b0) begin
        mon_starts++;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
        end else begin
          mon_busy = 1'b1;
          f = exp_q.pop_front();
          bad = 0;
          aborted = 1'b0;
          for (int c = 0; c < 10 * f.div; c++) begin
            if (c > 0) @(negedge clk_i);
            if (rst_i) begin
              aborted = 1'b1;
              break;
            end
            slot = c / f.div;
            if (slot == 0)      expb = 1'b0;
            else if (slot == 9) expb = 1'b1;
            else                expb = f.data[slot-1];
            if (tx_o !== expb) bad++;
          end
          if (!aborted) begin
            n_total++;
            if (bad == 0) n_pass++;
            else $display("FAIL frame_shape: byte 0x%02h div %0d had %0d wrong tx_o cycles, required 0",
                          f.data, f.div, bad);
            mon_frames++;
          end
          mon_busy = 1'b0;
        end
      end
      prev = tx_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    a_i  = a;
    wd_i = d;
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    a_i = a;
    #1;
    d = rd_o;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(irq_o === 1'b1 && !mon_busy && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    n_total++;
    if (n < budget) n_pass++;
    else $display("FAIL %s_timeout: idle not reached in %0d cycles, required within budget", tag, budget);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (start_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (start_q.size() < target) begin
      n_total++;
      $display("FAIL %s_timeout: %0d start bits seen, required %0d", tag, start_q.size(), target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    n_total++;
    if (tx_o !== 1'b1) $display("FAIL reset_tx: tx_o=%b, required 1", tx_o); else n_pass++;
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL reset_irq: irq_o=%b, required 1", irq_o); else n_pass++;
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL reset_status: got 0x%08h, required 0x00000001", d); else n_pass++;
    rd(A_BD, d);
    n_total++;
    if (d !== 32'd16) $display("FAIL reset_bauddiv: got %0d, required 16", d); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    int nbusy0;
    wr(A_BD, 32'd4);
    rd(A_BD, d);
    n_total++;
    if (d !== 32'd4) $display("FAIL bauddiv_rb4: got %0d, required 4", d); else n_pass++;
    exp_q.push_back('{8'hA5, 4});
    wr(A_TX, 32'h0000_00A5);
    n_total++;
    if (tx_o !== 1'b1) $display("FAIL latency_hold: tx_o=%b, required 1", tx_o); else n_pass++;
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL status_queued: got 0x%08h, required 0x00000000", d); else n_pass++;
    tick();
    n_total++;
    if (tx_o !== 1'b0) $display("FAIL latency_fall: tx_o=%b, required 0", tx_o); else n_pass++;
    nbusy0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_o[2] !== 1'b1) nbusy0++;
      tick();
    end
    n_total++;
    if (nbusy0 != 0) $display("FAIL busy_frame: BUSY low in %0d cycles, required 0", nbusy0); else n_pass++;
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL irq_after: irq_o=%b, required 1", irq_o); else n_pass++;
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL status_after: got 0x%08h, required 0x00000001", d); else n_pass++;
    wait_idle(100, "single");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int base;
    wr(A_BD, 32'd16);
    base = mon_frames;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) exp_q.push_back('{8'(i), 16});
      a_i  = A_TX;
      wd_i = 32'(i);
      we_i = 1'b1;
      tick();
      we_i = 1'b0;
      if (i == 9) begin
        rd(A_ST, d);
        n_total++;
        if (d !== 32'h6) $display("FAIL full_after9: got 0x%08h, required 0x00000006", d); else n_pass++;
      end
    end
    rd(A_ST, d);
    n_total++;
    if (d !== 32'hE) $display("FAIL ovf_set: got 0x%08h, required 0x0000000e", d); else n_pass++;
    wr(A_ST, 32'h8);
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h6) $display("FAIL ovf_clear: got 0x%08h, required 0x00000006", d); else n_pass++;
    wait_idle(9 * 160 + 100, "overflow");
    n_total++;
    if (mon_frames - base != 9) $display("FAIL frame_count9: got %0d frames, required 9", mon_frames - base);
    else n_pass++;
  endtask

  task automatic test_bauddiv();
    logic [31:0] d;
    int base;
    int s;
    int n;
    wr(A_BD, 32'd0);
    rd(A_BD, d);
    n_total++;
    if (d !== 32'd1) $display("FAIL bauddiv_zero: got %0d, required 1", d); else n_pass++;
    wr(A_BD, 32'd4);
    base = start_q.size();
    exp_q.push_back('{8'h3C, 4});
    wr(A_TX, 32'h3C);
    repeat (6) tick();
    wr(A_BD, 32'd8);
    exp_q.push_back('{8'hC3, 8});
    wr(A_TX, 32'hC3);
    wait_starts(base + 2, 200, "bauddiv_starts");
    if (start_q.size() >= base + 2) begin
      s = start_q[base + 1];
      n_total++;
      if (s - start_q[base] != 41)
        $display("FAIL old_period: start-to-start %0d cycles, required 41", s - start_q[base]);
      else n_pass++;
      n = 0;
      while (irq_o !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      n_total++;
      if (cyc - s != 80) $display("FAIL new_period: frame lasted %0d cycles, required 80", cyc - s);
      else n_pass++;
    end
    wait_idle(200, "bauddiv");
  endtask

  task automatic test_decode();
    logic [31:0] d;
    int starts0;
    starts0 = mon_starts;
    rd(A_RSV, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rd_reserved: got 0x%08h, required 0", d); else n_pass++;
    rd(BASE + 32'h10, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rd_unselected: got 0x%08h, required 0", d); else n_pass++;
    rd(A_TX, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rd_txdata: got 0x%08h, required 0", d); else n_pass++;
    rd(BASE + 32'h6, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL rd_lowbits: got 0x%08h, required 0x00000001", d); else n_pass++;
    wr(BASE + 32'h10, 32'h55);
    wr(A_RSV, 32'h77);
    wr(BASE + 32'h18, 32'd3);
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL unsel_store: STATUS 0x%08h, required 0x00000001", d); else n_pass++;
    rd(A_BD, d);
    n_total++;
    if (d !== 32'd8) $display("FAIL unsel_baud: BAUDDIV %0d, required 8", d); else n_pass++;
    repeat (30) tick();
    n_total++;
    if (mon_starts != starts0) $display("FAIL unsel_frames: %0d frames started, required 0", mon_starts - starts0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int frames0;
    int starts0;
    wr(A_BD, 32'd16);
    frames0 = mon_frames;
    starts0 = mon_starts;
    exp_q.push_back('{8'h81, 16});
    wr(A_TX, 32'h81);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    wr(A_TX, 32'h33);
    repeat (48) tick();
    rst_i = 1'b1;
    tick();
    n_total++;
    if (tx_o !== 1'b1) $display("FAIL midrst_tx: tx_o=%b, required 1", tx_o); else n_pass++;
    rst_i = 1'b0;
    rd(A_ST, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL midrst_status: got 0x%08h, required 0x00000001", d); else n_pass++;
    rd(A_BD, d);
    n_total++;
    if (d !== 32'd16) $display("FAIL midrst_baud: got %0d, required 16", d); else n_pass++;
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL midrst_irq: irq_o=%b, required 1", irq_o); else n_pass++;
    repeat (400) tick();
    n_total++;
    if (mon_starts != starts0 + 1 || mon_frames != frames0)
      $display("FAIL midrst_frames: %0d starts %0d complete, required 1 start 0 complete",
               mon_starts - starts0, mon_frames - frames0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base;
    wr(A_BD, 32'd2);
    base = start_q.size();
    exp_q.push_back('{8'h5A, 2});
    exp_q.push_back('{8'hF0, 2});
    a_i  = A_TX;
    wd_i = 32'h5A;
    we_i = 1'b1;
    tick();
    wd_i = 32'hF0;
    tick();
    we_i = 1'b0;
    wait_starts(base + 2, 100, "b2b_starts");
    if (start_q.size() >= base + 2) begin
      n_total++;
      if (start_q[base + 1] - start_q[base] != 21)
        $display("FAIL b2b_gap: start-to-start %0d cycles, required 21", start_q[base + 1] - start_q[base]);
      else n_pass++;
    end
    wait_idle(200, "b2b");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_bauddiv();
    test_decode();
    test_reset_mid();
    test_back_to_back();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_responder.md
Name: uart_tx_responder

Overview:
- Memory-mapped UART transmitter that answers the core's data-memory port: stores, address, write enable and load data use the same signal set as data memory.
- Core stores push bytes into a TX FIFO; an 8N1 serialiser drains the FIFO onto tx_o.
- Status and divider registers are readable through rd_o.
- Sits beside data_memory; the top level muxes rd_o into read_data on address decode.

Parameters:
- RegBits, 32, data/address width of the bus.
- BaseAddr, 32'h0000_1000, 16-byte-aligned base of the register window.
- FifoDepth, 8, TX FIFO entries; power of two, at least 2.
- ClkDiv, 16, reset value of BAUDDIV (clock cycles per bit).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- a_i  in  RegBits  byte address from the ALU result.
- wd_i  in  RegBits  store data.
- we_i  in  1  store enable; commits on the rising clk_i edge.
- rd_o  out  RegBits  combinational load data; 0 when not selected.
- tx_o  out  1  serial line; idle high.
- irq_o  out  1  high while FIFO is empty and the serialiser is idle.

Behaviour:
- Select: sel = (a_i[RegBits-1:4] == BaseAddr[RegBits-1:4]). Register offset is a_i[3:2]; a_i[1:0] is ignored. When sel=0, we_i is ignored.
- Offset 0, TXDATA (write only):
  - Write pushes wd_i[7:0] when the FIFO is not full.
  - Write when full drops the byte and sets OVF.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0 EMPTY, bit1 FULL, bit2 BUSY (FSM not in IDLE), bit3 OVF (sticky); all other bits 0.
  - A write with wd_i[3]=1 clears OVF.
- Offset 2, BAUDDIV:
  - 16-bit register; reads return zero-extended.
  - Write loads wd_i[15:0]; a written value of 0 is stored as 1.
- Offset 3: reserved. Reads 0, writes ignored.
- rd_o is purely combinational from a_i and the current register state (single-cycle core; no read latency).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO is non-empty: pop the head into the shift register, latch BAUDDIV into div_q, clear the bit counter, go to START.
  - START: tx_o=0 for div_q cycles, then go to DATA.
  - DATA: tx_o=shift[0] for div_q cycles per bit. Shift right after each bit. After 8 bits go to STOP.
  - STOP: tx_o=1 for div_q cycles, then go to IDLE.
  - A frame lasts exactly 10*div_q cycles.
- BAUDDIV writes during a frame take effect at the next frame only.
- Latency: a TXDATA write committed at edge N makes tx_o fall after edge N+1 (FIFO previously empty, FSM idle).
- Back-to-back frames: IDLE lasts exactly one cycle between STOP and the next START.
- Simultaneous push and pop while full: the push is accepted (pop frees the slot first); count is unchanged and OVF is not set.
- FIFO pointers wrap modulo FifoDepth. Count is kept in $clog2(FifoDepth)+1 bits.
- Reset (at any time, including mid-frame), effective from the next edge:
  - FIFO emptied; FSM to IDLE.
  - tx_o=1, OVF=0, BAUDDIV=ClkDiv, irq_o=1.
  - Shift register and counters cleared.

Decomposition:
- uart_pkg:
  - state_t enum (IDLE/START/DATA/STOP).
  - Offset constants OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_BAUDDIV=2'd2.
  - STATUS bit indices.
- Sub-module sync_fifo (params Width, Depth):
  - Inputs push/pop; outputs full/empty/count; registered storage.
  - Supports push+pop on the same edge when full.

Test Plan:
- Reset, BAUDDIV=4, write TXDATA=0xA5:
  - tx_o low for 4 cycles.
  - Then 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then high for 4 cycles.
  - BUSY=1 throughout; irq_o=1 and STATUS=0x1 afterwards.
- BAUDDIV=16, 10 TXDATA writes on consecutive cycles:
  - Writes 2..9 fill the FIFO (FULL=1 after the 9th).
  - Write 10 is dropped and STATUS bit3=1.
  - Writing STATUS with 0x8 clears OVF.
  - Exactly 9 frames are observed on tx_o.
- Write BAUDDIV=0, read back -> 1. Write BAUDDIV=8 mid-frame -> current frame keeps the old period; next frame lasts 80 cycles.
- Reads at BaseAddr+0xC, at BaseAddr+0x10 (unselected), and of TXDATA -> rd_o=0. A store to BaseAddr+0x10 leaves the FIFO unchanged.
- rst_i pulsed mid-DATA with 3 bytes queued -> tx_o=1 next cycle, STATUS=0x1, BAUDDIV=16, no further frames.
- Two bytes written back-to-back, BAUDDIV=2 -> frames separated by exactly one idle-high cycle after the stop bit (21 cycles from first start edge to second start edge).
